// File: rtl/instruction_fetch_unit_pkg.sv
// IF-stage shared definitions: state encodings, defaults
// and the IF/ID bundle.
package instruction_fetch_unit_pkg;

  localparam logic [1:0] S_FETCH   = 2'd0;
  localparam logic [1:0] S_HOLD    = 2'd1;
  localparam logic [1:0] S_DISCARD = 2'd2;

  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] instr;
    logic        valid;
  } if_id_t;

  function automatic logic [31:0] word_align(
    input logic [31:0] a
  );
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Instruction memory read port between the IF stage
// (master) and the instruction memory (slave).
interface instruction_fetch_unit_if;

  logic [31:0] IMEM_ADDR;
  logic        IMEM_READ;
  logic [31:0] IMEM_READDATA;
  logic        IMEM_BUSYWAIT;

  modport master (
    output IMEM_ADDR,
    output IMEM_READ,
    input  IMEM_READDATA,
    input  IMEM_BUSYWAIT
  );

  modport slave (
    input  IMEM_ADDR,
    input  IMEM_READ,
    output IMEM_READDATA,
    output IMEM_BUSYWAIT
  );

endinterface

// File: rtl/if_id_register.sv
// IF/ID pipeline register; flush beats load, and with
// neither asserted the contents hold.
module if_id_register
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        flush,
  input  logic [31:0] pc_i,
  input  logic [31:0] instr_i,
  output if_id_t      q_o
);

  if_id_t r_d, r_q;

  always_comb begin
    r_d = r_q;
    if (flush) begin
      r_d.instr = NOP_INSTR;
      r_d.valid = 1'b0;
    end else if (load) begin
      r_d.pc    = pc_i;
      r_d.pc4   = pc_i + 32'd4;
      r_d.instr = instr_i;
      r_d.valid = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q.pc    <= '0;
      r_q.pc4   <= '0;
      r_q.instr <= NOP_INSTR;
      r_q.valid <= 1'b0;
    end else begin
      r_q <= r_d;
    end
  end

  assign q_o = r_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// IF stage: PC register, next-PC selection, fetch FSM
// and a one-entry hold buffer for stalled responses.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        STALL,
  input  logic        BRANCH_TAKEN,
  input  logic [31:0] BRANCH_TARGET,
  instruction_fetch_unit_if.master imem,
  output logic [31:0] IF_ID_PC,
  output logic [31:0] IF_ID_PC4,
  output logic [31:0] IF_ID_INSTRUCTION,
  output logic        IF_ID_VALID
);

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] old_pc_q, old_pc_d;
  logic [31:0] hold_pc_q, hold_pc_d;
  logic [31:0] hold_ins_q, hold_ins_d;
  logic        hold_vld_q, hold_vld_d;

  logic        ld, fl, resp;
  logic [31:0] ld_pc, ld_ins;
  if_id_t      ifid;

  assign resp = !imem.IMEM_BUSYWAIT;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    old_pc_d   = old_pc_q;
    hold_pc_d  = hold_pc_q;
    hold_ins_d = hold_ins_q;
    hold_vld_d = hold_vld_q;
    ld         = 1'b0;
    fl         = 1'b0;
    ld_pc      = pc_q;
    ld_ins     = imem.IMEM_READDATA;
    if (BRANCH_TAKEN) begin
      fl         = 1'b1;
      pc_d       = word_align(BRANCH_TARGET);
      hold_vld_d = 1'b0;
      // an in-flight read must finish at its old address
      if (state_q == S_FETCH && !resp) begin
        state_d  = S_DISCARD;
        old_pc_d = pc_q;
      end else if (state_q != S_DISCARD) begin
        state_d = S_FETCH;
      end
    end else begin
      unique case (state_q)
        S_FETCH: begin
          if (resp) begin
            pc_d = pc_q + 32'd4;
            if (STALL) begin
              hold_pc_d  = pc_q;
              hold_ins_d = imem.IMEM_READDATA;
              hold_vld_d = 1'b1;
              state_d    = S_HOLD;
            end else begin
              ld = 1'b1;
            end
          end else if (!STALL) begin
            fl = 1'b1;
          end
        end
        S_HOLD: begin
          if (!STALL) begin
            ld         = hold_vld_q;
            fl         = !hold_vld_q;
            ld_pc      = hold_pc_q;
            ld_ins     = hold_ins_q;
            hold_vld_d = 1'b0;
            state_d    = S_FETCH;
          end
        end
        S_DISCARD: begin
          if (resp) state_d = S_FETCH;
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q    <= S_FETCH;
      pc_q       <= RESET_PC;
      old_pc_q   <= '0;
      hold_pc_q  <= '0;
      hold_ins_q <= '0;
      hold_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      old_pc_q   <= old_pc_d;
      hold_pc_q  <= hold_pc_d;
      hold_ins_q <= hold_ins_d;
      hold_vld_q <= hold_vld_d;
    end
  end

  assign imem.IMEM_ADDR =
    (state_q == S_DISCARD) ? old_pc_q : pc_q;
  assign imem.IMEM_READ =
    RESET && (state_q != S_HOLD);

  if_id_register #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id (
    .clk     (CLK),
    .rst_n   (RESET),
    .load    (ld),
    .flush   (fl),
    .pc_i    (ld_pc),
    .instr_i (ld_ins),
    .q_o     (ifid)
  );

  assign IF_ID_PC          = ifid.pc;
  assign IF_ID_PC4         = ifid.pc4;
  assign IF_ID_INSTRUCTION = ifid.instr;
  assign IF_ID_VALID       = ifid.valid;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for the IF stage with a simple
// address-derived instruction memory model.
module tb_instruction_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        br;
  logic [31:0] tgt;
  logic [31:0] if_pc, if_pc4, if_ins;
  logic        if_vld;
  int          checks = 0;
  int          errors = 0;

  instruction_fetch_unit_if bus ();

  instruction_fetch_unit dut (
    .CLK               (clk),
    .RESET             (rst_n),
    .STALL             (stall),
    .BRANCH_TAKEN      (br),
    .BRANCH_TARGET     (tgt),
    .imem              (bus.master),
    .IF_ID_PC          (if_pc),
    .IF_ID_PC4         (if_pc4),
    .IF_ID_INSTRUCTION (if_ins),
    .IF_ID_VALID       (if_vld)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(
    input logic [31:0] a
  );
    return 32'hCAFE_0000 | {16'h0, a[15:0]};
  endfunction

  always_comb bus.IMEM_READDATA = mem(bus.IMEM_ADDR);

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    stall = 1'b0;
    br    = 1'b0;
    tgt   = '0;
    bus.IMEM_BUSYWAIT = 1'b0;
    tick();
    check("rst_vld", 32'(if_vld), 0);
    check("rst_ins", if_ins, NOP);
    check("rst_rd", 32'(bus.IMEM_READ), 0);
    rst_n = 1'b1;
    tick();
    tick();
    check("pre_pc", if_pc, 32'h4);
    // asynchronous reset between edges
    #2 rst_n = 1'b0;
    #1;
    check("ar_vld", 32'(if_vld), 0);
    check("ar_ins", if_ins, NOP);
    check("ar_pc", if_pc, 0);
    check("ar_pc4", if_pc4, 0);
    check("ar_rd", 32'(bus.IMEM_READ), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("t1_pc0", if_pc, 32'h0);
    check("t1_v0", 32'(if_vld), 1);
    check("t1_i0", if_ins, mem(32'h0));
    tick();
    check("t1_pc4", if_pc, 32'h4);
    tick();
    check("t1_pc8", if_pc, 32'h8);
    check("t1_p48", if_pc4, 32'hC);

    do_reset();
    tick();
    tick();
    bus.IMEM_BUSYWAIT = 1'b1;
    #1;
    check("t2_a0", bus.IMEM_ADDR, 32'h8);
    tick();
    check("t2_v1", 32'(if_vld), 0);
    check("t2_i1", if_ins, NOP);
    check("t2_a1", bus.IMEM_ADDR, 32'h8);
    tick();
    check("t2_v2", 32'(if_vld), 0);
    check("t2_a2", bus.IMEM_ADDR, 32'h8);
    bus.IMEM_BUSYWAIT = 1'b0;
    tick();
    check("t2_pc", if_pc, 32'h8);
    check("t2_v3", 32'(if_vld), 1);
    check("t2_i3", if_ins, mem(32'h8));

    do_reset();
    tick();
    tick();
    stall = 1'b1;
    tick();
    check("t3_pc1", if_pc, 32'h4);
    check("t3_rd1", 32'(bus.IMEM_READ), 0);
    tick();
    tick();
    check("t3_pc3", if_pc, 32'h4);
    check("t3_v3", 32'(if_vld), 1);
    check("t3_rd3", 32'(bus.IMEM_READ), 0);
    stall = 1'b0;
    tick();
    check("t3_pc8", if_pc, 32'h8);
    check("t3_i8", if_ins, mem(32'h8));
    check("t3_a", bus.IMEM_ADDR, 32'hC);
    tick();
    check("t3_pcC", if_pc, 32'hC);

    bus.IMEM_BUSYWAIT = 1'b1;
    br  = 1'b1;
    tgt = 32'h100;
    tick();
    check("t4_v0", 32'(if_vld), 0);
    check("t4_a0", bus.IMEM_ADDR, 32'h10);
    check("t4_rd0", 32'(bus.IMEM_READ), 1);
    br = 1'b0;
    tick();
    check("t4_a1", bus.IMEM_ADDR, 32'h10);
    check("t4_v1", 32'(if_vld), 0);
    bus.IMEM_BUSYWAIT = 1'b0;
    tick();
    check("t4_v2", 32'(if_vld), 0);
    check("t4_a2", bus.IMEM_ADDR, 32'h100);
    tick();
    check("t4_pc", if_pc, 32'h100);
    check("t4_i", if_ins, mem(32'h100));

    stall = 1'b1;
    tick();
    check("t5_rd", 32'(bus.IMEM_READ), 0);
    check("t5_pc", if_pc, 32'h100);
    br  = 1'b1;
    tgt = 32'h203;
    tick();
    check("t5_v", 32'(if_vld), 0);
    check("t5_i", if_ins, NOP);
    check("t5_a", bus.IMEM_ADDR, 32'h200);
    check("t5_rd2", 32'(bus.IMEM_READ), 1);
    br    = 1'b0;
    stall = 1'b0;
    tick();
    check("t5_pc2", if_pc, 32'h200);
    check("t5_i2", if_ins, mem(32'h200));

    br  = 1'b1;
    tgt = 32'hFFFF_FFFC;
    tick();
    check("t6_a0", bus.IMEM_ADDR, 32'hFFFF_FFFC);
    br = 1'b0;
    tick();
    check("t6_pc", if_pc, 32'hFFFF_FFFC);
    check("t6_pc4", if_pc4, 32'h0);
    check("t6_a1", bus.IMEM_ADDR, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
